// File: rtl/rca_wb_drain.sv
// rca_wb_drain
// Receiving end of the RCA writeback interface. Each wb_done pulse captures one
// multi-port RCA result (id, NUM_WRITE_PORTS data words and the matching
// destination register addresses) into a small FIFO. A three-state FSM then
// serialises the head entry into the single register-file write port, skipping
// ports whose destination is x0 at zero cost. Once the last write of an entry
// has been acked, it pulses retire for one cycle and pops the entry.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   wb_done         result valid (one-cycle pulse)
//   wb_id           instruction id of the result
//   wb_rd           result data, port i at [i*XLEN +: XLEN]
//   wb_dest_addrs   destination register per port, port i at [i*5 +: 5]; 0 = unused
//   wb_ready        FIFO not full (from registered count only)
//   rf_we/rf_waddr/rf_wdata/rf_wid  register-file write request, held until rf_ack
//   rf_ack          write accepted this cycle (ignored while rf_we=0)
//   retire_valid/retire_id          one-cycle retire pulse and its id
//   busy            FIFO non-empty or FSM not idle
//   overflow_err    sticky: wb_done arrived while the FIFO was full
module rca_wb_drain #(
  parameter int NUM_WRITE_PORTS = 5,
  parameter int XLEN            = 32,
  parameter int ID_W            = 3,
  parameter int FIFO_DEPTH      = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wb_done,
  input  logic [ID_W-1:0]               wb_id,
  input  logic [NUM_WRITE_PORTS*XLEN-1:0] wb_rd,
  input  logic [NUM_WRITE_PORTS*5-1:0]  wb_dest_addrs,
  output logic                          wb_ready,
  output logic                          rf_we,
  output logic [4:0]                    rf_waddr,
  output logic [XLEN-1:0]               rf_wdata,
  output logic [ID_W-1:0]               rf_wid,
  input  logic                          rf_ack,
  output logic                          retire_valid,
  output logic [ID_W-1:0]               retire_id,
  output logic                          busy,
  output logic                          overflow_err
);

  localparam int PW = (NUM_WRITE_PORTS > 1) ? $clog2(NUM_WRITE_PORTS) : 1;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRAIN,
    S_RETIRE
  } state_e;

  typedef struct packed {
    logic          found;
    logic [PW-1:0] idx;
  } srch_t;

  // Lowest port index >= start whose destination is non-zero. Scanning from
  // the top down lets the lowest qualifying index overwrite the result last.
  function automatic srch_t find_port(input logic [NUM_WRITE_PORTS*5-1:0] dest,
                                      input int start);
    srch_t r;
    r = '0;
    for (int i = NUM_WRITE_PORTS - 1; i >= 0; i--) begin
      if (i >= start && dest[i*5 +: 5] != 5'd0) begin
        r.found = 1'b1;
        r.idx   = PW'(i);
      end
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  logic [ID_W-1:0]                 id_mem   [FIFO_DEPTH];
  logic [NUM_WRITE_PORTS*XLEN-1:0] rd_mem   [FIFO_DEPTH];
  logic [NUM_WRITE_PORTS*5-1:0]    dest_mem [FIFO_DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;

  logic push;
  logic pop;

  assign wb_ready = (count_q < CW'(FIFO_DEPTH));
  assign push     = wb_done && wb_ready;

  // NOTE: the storage array has no reset; count/pointers qualify every read,
  // so clearing the data would only add reset fan-out with no functional gain.
  always_ff @(posedge clk) begin
    if (push) begin
      id_mem[wr_ptr_q]   <= wb_id;
      rd_mem[wr_ptr_q]   <= wb_rd;
      dest_mem[wr_ptr_q] <= wb_dest_addrs;
    end
  end

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    overflow_d = overflow_q || (wb_done && !wb_ready);
    count_d    = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Head entry and the entry behind it (used to chain RETIRE straight into
  // the next DRAIN without a visit to IDLE).
  logic [ID_W-1:0]                 head_id;
  logic [NUM_WRITE_PORTS*XLEN-1:0] head_rd;
  logic [NUM_WRITE_PORTS*5-1:0]    head_dest;
  logic [AW-1:0]                   rd_ptr_nx;
  logic [NUM_WRITE_PORTS*5-1:0]    next_dest;

  assign head_id   = id_mem[rd_ptr_q];
  assign head_rd   = rd_mem[rd_ptr_q];
  assign head_dest = dest_mem[rd_ptr_q];
  assign rd_ptr_nx = rd_ptr_q + 1'b1;
  assign next_dest = dest_mem[rd_ptr_nx];

  // ---------------------------------------------------------------------------
  // Drain FSM
  // ---------------------------------------------------------------------------
  state_e        state_q, state_d;
  logic [PW-1:0] port_q, port_d;

  srch_t srch_head_first;
  srch_t srch_head_after;
  srch_t srch_next_first;

  assign srch_head_first = find_port(head_dest, 0);
  assign srch_head_after = find_port(head_dest, int'(port_q) + 1);
  assign srch_next_first = find_port(next_dest, 0);

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    port_d  = port_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          if (srch_head_first.found) begin
            state_d = S_DRAIN;
            port_d  = srch_head_first.idx;
          end else begin
            state_d = S_RETIRE;
          end
        end
      end
      S_DRAIN: begin
        if (rf_ack) begin
          if (srch_head_after.found) begin
            port_d = srch_head_after.idx;
          end else begin
            state_d = S_RETIRE;
          end
        end
      end
      S_RETIRE: begin
        pop = 1'b1;
        if (count_q > CW'(1)) begin
          if (srch_next_first.found) begin
            state_d = S_DRAIN;
            port_d  = srch_next_first.idx;
          end else begin
            state_d = S_RETIRE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      port_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      port_q     <= port_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: decoded from registered state, so an async reset clears them
  // immediately. The head entry cannot change while in DRAIN, which keeps the
  // write request stable until it is acked.
  // ---------------------------------------------------------------------------
  always_comb begin
    rf_we        = 1'b0;
    rf_waddr     = '0;
    rf_wdata     = '0;
    rf_wid       = '0;
    retire_valid = 1'b0;
    retire_id    = '0;
    if (state_q == S_DRAIN) begin
      rf_we    = 1'b1;
      rf_waddr = head_dest[port_q*5 +: 5];
      rf_wdata = head_rd[port_q*XLEN +: XLEN];
      rf_wid   = head_id;
    end
    if (state_q == S_RETIRE) begin
      retire_valid = 1'b1;
      retire_id    = head_id;
    end
  end

  assign busy         = (count_q != '0) || (state_q != S_IDLE);
  assign overflow_err = overflow_q;

endmodule

// File: tb/tb_rca_wb_drain.sv
// Self-checking bench for rca_wb_drain. Expected register-file writes and
// retire ids are pushed to queues when a result is sent; a negedge monitor
// pops and compares them as the DUT produces writes (rf_we && rf_ack) and
// retire pulses. Directed checks cover latency, backpressure, overflow and
// asynchronous reset.
module tb_rca_wb_drain;

  localparam int N     = 5;
  localparam int XLEN  = 32;
  localparam int ID_W  = 3;
  localparam int DEPTH = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 wb_done;
  logic [ID_W-1:0]      wb_id;
  logic [N*XLEN-1:0]    wb_rd;
  logic [N*5-1:0]       wb_dest_addrs;
  logic                 wb_ready;
  logic                 rf_we;
  logic [4:0]           rf_waddr;
  logic [XLEN-1:0]      rf_wdata;
  logic [ID_W-1:0]      rf_wid;
  logic                 rf_ack;
  logic                 retire_valid;
  logic [ID_W-1:0]      retire_id;
  logic                 busy;
  logic                 overflow_err;

  rca_wb_drain #(
    .NUM_WRITE_PORTS(N),
    .XLEN           (XLEN),
    .ID_W           (ID_W),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wb_done      (wb_done),
    .wb_id        (wb_id),
    .wb_rd        (wb_rd),
    .wb_dest_addrs(wb_dest_addrs),
    .wb_ready     (wb_ready),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .rf_wid       (rf_wid),
    .rf_ack       (rf_ack),
    .retire_valid (retire_valid),
    .retire_id    (retire_id),
    .busy         (busy),
    .overflow_err (overflow_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard and monitor
  // ---------------------------------------------------------------------------
  logic [39:0]     exp_wr_q[$];   // {addr, data, id}
  logic [ID_W-1:0] exp_ret_q[$];
  int              wr_cycles[$];
  int              retire_cyc = -1;
  int              n_ret = 0;
  logic [XLEN-1:0] last_wdata;
  logic            hold_pend = 1'b0;
  logic [39:0]     held;

  always @(negedge clk) begin
    if (rst) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        check("hold_we", 64'(rf_we), 64'd1);
        check("hold_req", 64'({rf_waddr, rf_wdata, rf_wid}), 64'(held));
      end
      hold_pend = 1'b0;
      if (rf_we) begin
        if (rf_ack) begin
          wr_cycles.push_back(cyc);
          last_wdata = rf_wdata;
          if (exp_wr_q.size() == 0)
            check("wr_unexpected", 64'(exp_wr_q.size()), 64'd1);
          else
            check("wr", 64'({rf_waddr, rf_wdata, rf_wid}), 64'(exp_wr_q.pop_front()));
        end else begin
          hold_pend = 1'b1;
          held      = {rf_waddr, rf_wdata, rf_wid};
        end
      end
      if (retire_valid) begin
        retire_cyc = cyc;
        n_ret++;
        if (exp_ret_q.size() == 0)
          check("retire_unexpected", 64'(exp_ret_q.size()), 64'd1);
        else
          check("retire_id", 64'(retire_id), 64'(exp_ret_q.pop_front()));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (all called at posedge + 1)
  // ---------------------------------------------------------------------------
  function automatic logic [N*5-1:0] dests(input int a0, a1, a2, a3, a4);
    return {5'(a4), 5'(a3), 5'(a2), 5'(a1), 5'(a0)};
  endfunction

  function automatic logic [N*XLEN-1:0] datas(input logic [XLEN-1:0] base);
    logic [N*XLEN-1:0] r;
    for (int i = 0; i < N; i++) r[i*XLEN +: XLEN] = base + XLEN'(i);
    return r;
  endfunction

  task automatic send(input logic [ID_W-1:0] id, input logic [N*5-1:0] dest,
                      input logic [N*XLEN-1:0] rd, input bit accept, output int t);
    t             = cyc;
    wb_done       = 1'b1;
    wb_id         = id;
    wb_rd         = rd;
    wb_dest_addrs = dest;
    if (accept) begin
      for (int i = 0; i < N; i++)
        if (dest[i*5 +: 5] != 5'd0)
          exp_wr_q.push_back({dest[i*5 +: 5], rd[i*XLEN +: XLEN], id});
      exp_ret_q.push_back(id);
    end
    @(posedge clk) #1;
    wb_done = 1'b0;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(posedge clk) #1;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k = 0;
    while ((busy || exp_ret_q.size() != 0) && k < budget) begin
      @(posedge clk) #1;
      k++;
    end
    if (k >= budget) check({tag, "_timeout"}, 64'(busy), 64'd0);
    check({tag, "_sb_empty"}, 64'(exp_wr_q.size() + exp_ret_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  initial begin
    int t, t1, r0;
    rst = 1'b1; wb_done = 1'b0; wb_id = '0; wb_rd = '0; wb_dest_addrs = '0; rf_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rf_we", 64'(rf_we), 64'd0);
    check("rst_rf_waddr", 64'(rf_waddr), 64'd0);
    check("rst_rf_wdata", 64'(rf_wdata), 64'd0);
    check("rst_rf_wid", 64'(rf_wid), 64'd0);
    check("rst_retire", 64'({retire_valid, retire_id}), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_overflow", 64'(overflow_err), 64'd0);
    check("rst_ready", 64'(wb_ready), 64'd1);
    rst = 1'b0;
    @(posedge clk) #1;

    // Single full result, ack tied high
    rf_ack = 1'b1;
    wr_cycles.delete();
    send(3'd2, dests(1, 2, 3, 4, 5), datas(32'hA000_0000), 1'b1, t);
    check("t1_busy_after_push", 64'(busy), 64'd1);
    wait_until(t + 8);
    check("t1_busy_T8", 64'(busy), 64'd0);
    check("t1_nwr", 64'(wr_cycles.size()), 64'd5);
    if (wr_cycles.size() == 5) begin
      check("t1_first_wr_cyc", 64'(wr_cycles[0] - t), 64'd2);
      check("t1_last_wr_cyc", 64'(wr_cycles[4] - t), 64'd6);
    end
    check("t1_retire_cyc", 64'(retire_cyc - t), 64'd7);
    wait_idle("t1", 50);

    // Sparse ports
    wr_cycles.delete();
    send(3'd5, dests(0, 7, 0, 0, 9), datas(32'h0000_B000), 1'b1, t);
    wait_idle("t2a", 50);
    check("t2a_nwr", 64'(wr_cycles.size()), 64'd2);
    if (wr_cycles.size() == 2) begin
      check("t2a_first_cyc", 64'(wr_cycles[0] - t), 64'd2);
      check("t2a_consecutive", 64'(wr_cycles[1] - wr_cycles[0]), 64'd1);
    end
    check("t2a_retire_cyc", 64'(retire_cyc - t), 64'd4);

    wr_cycles.delete();
    send(3'd6, dests(0, 0, 0, 0, 0), datas(32'h0000_C000), 1'b1, t);
    wait_idle("t2b", 50);
    check("t2b_nwr", 64'(wr_cycles.size()), 64'd0);
    check("t2b_retire_cyc", 64'(retire_cyc - t), 64'd2);

    // Backpressure: ack low for the first three write cycles
    wr_cycles.delete();
    rf_ack = 1'b0;
    send(3'd3, dests(10, 11, 12, 13, 14), datas(32'hD000_0000), 1'b1, t);
    wait_until(t + 5);
    rf_ack = 1'b1;
    wait_idle("t3", 50);
    check("t3_nwr", 64'(wr_cycles.size()), 64'd5);
    check("t3_retire_cyc", 64'(retire_cyc - t), 64'd10);

    // FIFO full / overflow
    rf_ack = 1'b0;
    r0 = n_ret;
    send(3'd1, dests(1, 0, 3, 0, 0), datas(32'h1100_0000), 1'b1, t1);
    check("t4_ready_one", 64'(wb_ready), 64'd1);
    send(3'd2, dests(0, 2, 0, 0, 6), datas(32'h2200_0000), 1'b1, t);
    check("t4_ready_full", 64'(wb_ready), 64'd0);
    check("t4_no_ovf_yet", 64'(overflow_err), 64'd0);
    send(3'd3, dests(8, 8, 8, 8, 8), datas(32'h3300_0000), 1'b0, t);
    check("t4_ovf_set", 64'(overflow_err), 64'd1);
    repeat (4) @(posedge clk) #1;
    check("t4_ovf_sticky", 64'(overflow_err), 64'd1);
    rf_ack = 1'b1;
    wait_idle("t4", 50);
    check("t4_nret", 64'(n_ret - r0), 64'd2);
    check("t4_ovf_held", 64'(overflow_err), 64'd1);

    // Duplicate destination: higher port written last
    send(3'd4, dests(4, 0, 4, 0, 0),
         {32'h5, 32'h4, 32'h22, 32'h2, 32'h11}, 1'b1, t);
    wait_idle("t5", 50);
    check("t5_last_wdata", 64'(last_wdata), 64'h22);

    // Async reset during the second write
    r0 = n_ret;
    send(3'd7, dests(1, 2, 3, 4, 5), datas(32'hE000_0000), 1'b1, t);
    wait_until(t + 3);
    check("t6_mid_drain", 64'(rf_we), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_we", 64'(rf_we), 64'd0);
    check("t6_rst_busy", 64'(busy), 64'd0);
    check("t6_rst_retire", 64'(retire_valid), 64'd0);
    check("t6_rst_ovf", 64'(overflow_err), 64'd0);
    exp_wr_q.delete();
    exp_ret_q.delete();
    @(posedge clk) #1;
    rst = 1'b0;
    repeat (3) @(posedge clk) #1;
    check("t6_no_retire", 64'(n_ret - r0), 64'd0);
    check("t6_idle", 64'(busy), 64'd0);
    wr_cycles.delete();
    send(3'd1, dests(9, 0, 0, 3, 0), datas(32'hF000_0000), 1'b1, t);
    wait_idle("t6", 50);
    check("t6_nwr", 64'(wr_cycles.size()), 64'd2);
    check("t6_retire_cyc", 64'(retire_cyc - t), 64'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rca_wb_drain.md
Name: rca_wb_drain

Overview:
- Receiving end of the RCA writeback interface.
- Captures each multi-port RCA result (done/id/rd[NUM_WRITE_PORTS]) together with the destination register addresses from the RCA config registers.
- Buffers results in a small FIFO and serialises them into the single CPU register-file write port with a valid/ack handshake.
- Emits one retire pulse per instruction id once all of that instruction's writes have landed.
- Sits between the RCA unit and the register file / retire logic.

Parameters:
- NUM_WRITE_PORTS, 5: result ports per RCA instruction.
- XLEN, 32: data width.
- ID_W, 3: instruction id width.
- FIFO_DEPTH, 2: buffered RCA results; power of two, ≥2.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous and active-high.
- wb_done  in  1  result valid, one-cycle pulse.
- wb_id  in  ID_W  instruction id.
- wb_rd  in  NUM_WRITE_PORTS*XLEN  result data; port i at bits [i*XLEN +: XLEN].
- wb_dest_addrs  in  NUM_WRITE_PORTS*5  destination register per port; 0 means the port is unused.
- wb_ready  out  1  FIFO not full; the issue side gates new RCA issue with it.
- rf_we  out  1  register-file write request.
- rf_waddr  out  5  write address.
- rf_wdata  out  XLEN  write data.
- rf_wid  out  ID_W  id of the owning instruction.
- rf_ack  in  1  write accepted this cycle.
- retire_valid  out  1  one-cycle pulse when all of an instruction's writes are complete.
- retire_id  out  ID_W  id being retired.
- busy  out  1  FIFO non-empty or FSM not IDLE.
- overflow_err  out  1  sticky: wb_done arrived while full.

Behaviour:
- Reset (async, rst=1): FIFO empty, pointers 0, FSM IDLE, port index 0.
  - Outputs: rf_we=0, rf_waddr=0, rf_wdata=0, rf_wid=0, retire_valid=0, retire_id=0, busy=0, overflow_err=0, wb_ready=1.
  - Reset mid-drain discards every buffered entry and any pending write; no retire is emitted.
- Push: wb_done=1 while not full → {id, rd[], dest_addrs[]} is written at the next clk edge and count increments.
  - wb_ready = (count < FIFO_DEPTH), derived from registered count only; a same-cycle pop does not free a slot.
  - wb_done while full: entry dropped, FIFO unchanged, overflow_err set and held until reset.
- FSM states:
  - IDLE → DRAIN when the FIFO is non-empty. p is loaded with the lowest index whose dest addr ≠ 0. If no such port exists, the transition goes to RETIRE instead.
  - DRAIN: rf_we=1, rf_waddr=dest[p], rf_wdata=rd[p], rf_wid=head id.
    - All four outputs are held stable until rf_ack=1.
    - On ack, p advances to the next higher index with dest ≠ 0, found by a combinational priority search, so skipped ports cost zero cycles.
    - If no further such port exists → RETIRE.
    - rf_we may be asserted in consecutive cycles when ack is continuous.
  - RETIRE: retire_valid=1 and retire_id=head id for exactly one cycle. The head is popped. Next state is DRAIN (same port search) if another entry remains, else IDLE.
- Write ordering: ascending port index. If two ports share a destination, the higher index is written last and wins.
- rf_ack is ignored when rf_we=0.
- Latency:
  - wb_done in cycle T → rf_we first high in cycle T+2 (T+1 edge enqueues, FSM leaves IDLE on the next edge).
  - Retire follows one cycle after the last ack.
- Simultaneous push and pop: both occur and count is unchanged.
- Pointers wrap modulo FIFO_DEPTH; count has $clog2(FIFO_DEPTH)+1 bits.
- busy = (count≠0) || (state≠IDLE).

Test Plan:
- Reset then a single result:
  - Stimulus: id=2, dest={1,2,3,4,5}, rd={A0..A4}, rf_ack tied 1.
  - Required: rf_we high for cycles T+2..T+6 with addrs 1,2,3,4,5 and data A0..A4; retire_valid with id=2 at T+7; busy low at T+8.
- Sparse ports:
  - Stimulus: dest={0,7,0,0,9}.
  - Required: exactly two writes (7←rd[1], 9←rd[4]) in consecutive cycles, then retire. All dest=0 → no rf_we, retire at T+2.
- Backpressure:
  - Stimulus: rf_ack low for 3 cycles on the first write.
  - Required: rf_waddr/rf_wdata/rf_wid stable across all 4 cycles; exactly one write per port; retire delayed by 3 cycles.
- FIFO full / overflow:
  - Stimulus: hold rf_ack=0 and send ids 1, 2, 3 back-to-back.
  - Required: wb_ready drops after id 2. id 3 is dropped and overflow_err=1 stays high. After releasing ack, retires come out as 1 then 2 only.
- Duplicate destination:
  - Stimulus: dest={4,0,4,0,0}, rd[0]=0x11, rd[2]=0x22.
  - Required: two writes to x4, the last with 0x22.
- Async reset mid-drain:
  - Stimulus: assert rst between clock edges during the second write.
  - Required: rf_we=0 immediately, busy=0, no retire_valid. A new result after deassert drains normally.
